multi_clock_divider: RTL and testbench

Parametrised N-channel clock/strobe generator. It succeeds the single-channel divider.
- Each channel takes a directly programmed half-period in cycles, so no runtime division is needed.
- Each channel runs in 50%-duty toggle mode or single-cycle pulse mode.
- New settings load through a valid/ready handshake and take effect glitch-free at period boundaries.
- It feeds the audio path: I2S BCLK/LRCLK, sample-rate ticks and SPI/SD clocks.

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clock_divider_channel.sv | 111 +++++++++++
 rtl/multi_clock_divider.sv | 67 ++++++
 tb/tb_multi_clock_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types for the multi-channel clock/strobe divider.
//   div_mode_t    : TOGGLE (50% duty clock) or PULSE (one-cycle tick)
//   div_cfg_t     : half-period + mode pair at the default counter width
//   DEFAULT_DIV_W : default half-period counter width
package clk_div_pkg;

  localparam int DEFAULT_DIV_W = 32;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } div_mode_t;

  typedef struct packed {
    logic [DEFAULT_DIV_W-1:0] half;
    div_mode_t                mode;
  } div_cfg_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, active and pending configuration
// registers, and the period-boundary logic that swaps a pending configuration
// in without producing a truncated half-period.
//
// Ports
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   i_enable   : channel run enable
//   i_cfg_load : an accepted configuration targets this channel
//   i_cfg_half : half-period in clk cycles (0 stops the channel)
//   i_cfg_mode : 0 = TOGGLE, 1 = PULSE
//   o_out      : generated clock (TOGGLE) or strobe level (PULSE)
//   o_strobe   : one-cycle pulse on each rising edge of o_out / each tick
//   o_pending  : a configuration is waiting for the next period boundary
module clock_divider_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_cfg_load,
  input  logic [DIV_W-1:0] i_cfg_half,
  input  logic             i_cfg_mode,
  output logic             o_out,
  output logic             o_strobe,
  output logic             o_pending
);

  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_pend_half;
  logic [DIV_W-1:0] r_cnt;
  div_mode_t        r_mode;
  div_mode_t        r_pend_mode;
  logic             r_pending;
  logic             r_out;
  logic             r_strobe;

  logic w_run;
  logic w_tick;
  logic w_boundary;

  assign w_run  = i_enable && (r_half != '0);
  assign w_tick = w_run && (r_cnt == (r_half - DIV_W'(1)));
  // A TOGGLE period ends on the tick that drives the output low; a PULSE
  // period ends on every tick.
  assign w_boundary = w_tick && ((r_mode == MODE_PULSE) || r_out);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_half      <= '0;
      r_mode      <= MODE_TOGGLE;
      r_pend_half <= '0;
      r_pend_mode <= MODE_TOGGLE;
      r_pending   <= 1'b0;
      r_cnt       <= '0;
      r_out       <= 1'b0;
      r_strobe    <= 1'b0;
    end else if (!w_run) begin
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_strobe <= 1'b0;
      // A stopped channel has no period to protect, so settings land at once.
      if (r_pending) begin
        r_half    <= r_pend_half;
        r_mode    <= r_pend_mode;
        r_pending <= 1'b0;
      end else if (i_cfg_load) begin
        r_half <= i_cfg_half;
        r_mode <= div_mode_t'(i_cfg_mode);
      end
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        if (r_mode == MODE_PULSE) begin
          r_out    <= 1'b1;
          r_strobe <= 1'b1;
        end else begin
          r_out    <= ~r_out;
          r_strobe <= ~r_out;
        end
      end else begin
        r_cnt    <= r_cnt + DIV_W'(1);
        r_strobe <= 1'b0;
        if (r_mode == MODE_PULSE) begin
          r_out <= 1'b0;
        end
      end

      if (w_boundary && r_pending) begin
        r_half    <= r_pend_half;
        r_mode    <= r_pend_mode;
        r_pending <= 1'b0;
      end

      // The top only asserts a load while pending is clear, so this never
      // collides with the boundary swap above.
      if (i_cfg_load) begin
        r_pend_half <= i_cfg_half;
        r_pend_mode <= div_mode_t'(i_cfg_mode);
        r_pending   <= 1'b1;
      end
    end
  end

  assign o_out     = r_out;
  assign o_strobe  = r_strobe;
  assign o_pending = r_pending;

endmodule

// File: rtl/multi_clock_divider.sv
// N-channel clock/strobe generator. The top only decodes the configuration
// handshake to the addressed channel and muxes back that channel's ready.
//
// Ports
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   enable    : per-channel run enable
//   cfg_valid : configuration request
//   cfg_ready : request can be accepted for cfg_ch (combinational on cfg_ch)
//   cfg_ch    : target channel; out-of-range indices are accepted and dropped
//   cfg_half  : half-period in clk cycles, 0 stops the channel
//   cfg_mode  : 0 = TOGGLE, 1 = PULSE
//   out       : per-channel clock / strobe level
//   strobe    : per-channel one-cycle tick
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = DEFAULT_DIV_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_half,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] strobe
);

  logic [NUM_CH-1:0]      w_pending;
  logic [NUM_CH-1:0]      w_load;
  logic [(1<<CH_W)-1:0]   w_pend_ext;
  logic                   w_accept;

  // Padding the pending vector to the full index range makes out-of-range
  // channels read as "not pending", i.e. always ready.
  always_comb begin
    w_pend_ext              = '0;
    w_pend_ext[NUM_CH-1:0]  = w_pending;
  end

  assign cfg_ready = ~w_pend_ext[cfg_ch];
  assign w_accept  = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_load[g] = w_accept && (cfg_ch == CH_W'(g));

    clock_divider_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (enable[g]),
      .i_cfg_load (w_load[g]),
      .i_cfg_half (cfg_half),
      .i_cfg_mode (cfg_mode),
      .o_out      (out[g]),
      .o_strobe   (strobe[g]),
      .o_pending  (w_pending[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 32;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_half;
  logic              cfg_mode;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] strobe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[NUM_CH][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_mode  (cfg_mode),
    .out       (out),
    .strobe    (strobe)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected strobe cycle numbers for one channel: first, first+step, ... <= last.
  task automatic push_train(input int ch, input int first, input int step, input int last);
    for (int t = first; t <= last; t += step) exp_q[ch].push_back(t);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive one request for a single cycle, checking ready before the edge.
  task automatic do_cfg(input int ch, input int half, input logic mode,
                        input logic exp_rdy, input string name);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_half  = DIV_W'(half);
    cfg_mode  = mode;
    #1;
    chk(name, cfg_ready, exp_rdy);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the head of its channel's queue; an
  // expected cycle that passes without a strobe is reported as missed.
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_strobe ch%0d: no strobe seen, expected at cycle %0d", c, exp_q[c][0]);
        void'(exp_q[c].pop_front());
      end
      if (strobe[c]) begin
        checks++;
        if (exp_q[c].size() > 0 && exp_q[c][0] == cyc) begin
          void'(exp_q[c].pop_front());
        end else begin
          errors++;
          $display("FAIL unexpected_strobe ch%0d: strobe at cycle %0d, next expected %0d",
                   c, cyc, (exp_q[c].size() > 0) ? exp_q[c][0] : -1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int k0;
    int rst_c;
    int end_c;

    rst_n     = 1'b0;
    enable    = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_half  = '0;
    cfg_mode  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_out", out, 0);
    chk("reset_strobe", strobe, 0);
    chk("reset_ready", cfg_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", cfg_ready, 1);
    chk("post_reset_out", out, 0);

    // ch0 TOGGLE H=4: rises 4 edges after enable, period 8.
    do_cfg(0, 4, 1'b0, 1'b1, "cfg_ch0_h4_ready");
    enable[0] = 1'b1;
    k0 = cyc;
    push_train(0, k0 + 4, 8, k0 + 28);
    wait_cyc(k0 + 3);  chk("ch0_low_before_first_rise", out[0], 0);
    wait_cyc(k0 + 4);  chk("ch0_first_rise", out[0], 1);
    wait_cyc(k0 + 7);  chk("ch0_high_last", out[0], 1);
    wait_cyc(k0 + 8);  chk("ch0_first_fall", out[0], 0);

    // ch1 PULSE H=5, ch2 TOGGLE H=1.
    wait_cyc(k0 + 10);
    do_cfg(1, 5, 1'b1, 1'b1, "cfg_ch1_ready");
    do_cfg(2, 1, 1'b0, 1'b1, "cfg_ch2_ready");
    enable[2:1] = 2'b11;
    push_train(1, k0 + 17, 5, k0 + 60);
    push_train(2, k0 + 13, 2, k0 + 60);
    wait_cyc(k0 + 13); chk("ch2_high", out[2], 1);
    wait_cyc(k0 + 14); chk("ch2_low", out[2], 0);
    wait_cyc(k0 + 15); chk("ch2_high_again", out[2], 1);
    wait_cyc(k0 + 17); chk("ch1_pulse_out", out[1], 1);
    wait_cyc(k0 + 18); chk("ch1_pulse_gone", out[1], 0);

    // Reconfigure ch0 to H=2 mid high phase; takes effect at the fall at k0+32.
    wait_cyc(k0 + 29);
    chk("ch0_high_at_reconfig", out[0], 1);
    do_cfg(0, 2, 1'b0, 1'b1, "cfg_ch0_h2_ready");
    push_train(0, k0 + 34, 4, k0 + 42);
    // While pending: ch0 refused, ch3 accepted.
    do_cfg(0, 7, 1'b0, 1'b0, "cfg_ch0_refused_while_pending");
    do_cfg(3, 3, 1'b1, 1'b1, "cfg_ch3_accepted_while_ch0_pending");
    cfg_ch = 2'd0;
    #1;
    chk("ch0_ready_after_boundary", cfg_ready, 1);
    chk("ch0_low_at_boundary", out[0], 0);
    enable[3] = 1'b1;
    push_train(3, k0 + 35, 3, k0 + 60);

    // Pending config on ch0, then stop before its boundary.
    wait_cyc(k0 + 40);
    do_cfg(0, 3, 1'b0, 1'b1, "cfg_ch0_h3_ready");
    chk("ch0_ready_low_pending", cfg_ready, 0);
    wait_cyc(k0 + 42);
    chk("ch0_high_before_stop", out[0], 1);
    enable[0] = 1'b0;
    @(negedge clk);
    chk("ch0_out_after_stop", out[0], 0);
    chk("ch0_ready_after_stop", cfg_ready, 1);
    wait_cyc(k0 + 45);
    enable[0] = 1'b1;
    push_train(0, k0 + 48, 6, k0 + 60);
    wait_cyc(k0 + 47); chk("ch0_restart_low", out[0], 0);
    wait_cyc(k0 + 48); chk("ch0_restart_rise", out[0], 1);

    // Mid-run reset clears every channel; enables stay high.
    rst_c = k0 + 60;
    wait_cyc(rst_c);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_out", out, 0);
    chk("midrun_reset_strobe", strobe, 0);
    rst_n = 1'b1;
    wait_cyc(rst_c + 10);
    chk("idle_after_reset_out", out, 0);
    chk("idle_after_reset_ready", cfg_ready, 1);
    do_cfg(1, 2, 1'b1, 1'b1, "cfg_ch1_after_reset_ready");
    end_c = rst_c + 30;
    push_train(1, rst_c + 13, 2, end_c);
    wait_cyc(rst_c + 13); chk("ch1_after_reset_pulse", out[1], 1);
    wait_cyc(rst_c + 20); chk("ch0_still_idle", out[0], 0);
    wait_cyc(end_c);
    enable = '0;
    wait_cyc(end_c + 4);
    chk("all_out_idle_at_end", out, 0);
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("queue_empty_ch%0d", c), exp_q[c].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
